led_fade_driver: RTL and testbench



---
 rtl/led_fade_driver.sv | 158 +++++++++++++++
 tb/tb_led_fade_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// Two-channel LED fade driver: synchronises an active-low blink request and
// ramps each pin through PWM brightness levels instead of hard on/off steps.
module led_fade_driver #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PWM_BITS = 6,
    parameter int unsigned FADE_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_led_n,
    input  logic       i_bypass,
    output logic [1:0] o_led_n,
    output logic       o_busy
);

    localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PWM_BITS-1:0] MAX_M1    = MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] ONE       = PWM_BITS'(1);
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [FADE_W-1:0]   FADE_LAST = FADE_W'(FADE_DIV - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } state_e;

    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [FADE_W-1:0]   fade_cnt_q, fade_cnt_d;
    state_e              state_q [2];
    state_e              state_d [2];
    logic [PWM_BITS-1:0] level_q [2];
    logic [PWM_BITS-1:0] level_d [2];
    logic [1:0]          led_n_q, led_n_d;
    logic                busy_q, busy_d;

    logic [1:0] req_c;
    logic       pwm_tick_c;
    logic       period_end_c;
    logic       step_c;
    logic [1:0] dir_flip_c;
    logic [1:0] on_c;
    logic [1:0] moving_c;

    // Synchroniser and timebase: prescaler -> PWM counter -> fade divider
    always_comb begin
        sync1_d      = i_led_n;
        sync2_d      = sync1_q;
        req_c        = ~sync2_q;

        pwm_tick_c   = (pre_cnt_q == PRE_LAST);
        period_end_c = pwm_tick_c && (pwm_cnt_q == MAX);
        step_c       = period_end_c && (fade_cnt_q == FADE_LAST);

        pre_cnt_d    = pwm_tick_c ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d    = pwm_tick_c ? pwm_cnt_q + ONE : pwm_cnt_q;
        fade_cnt_d   = fade_cnt_q;
        if (period_end_c) begin
            fade_cnt_d = (fade_cnt_q == FADE_LAST) ? '0 : fade_cnt_q + FADE_W'(1);
        end
    end

    // Per-channel fade FSM; a direction change suppresses the level step that cycle
    always_comb begin
        dir_flip_c = '0;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];
            unique case (state_q[i])
                ST_OFF: begin
                    if (req_c[i]) state_d[i] = ST_RISE;
                end
                ST_RISE: begin
                    if (!req_c[i]) begin
                        dir_flip_c[i] = 1'b1;
                        state_d[i]    = ST_FALL;
                    end else if (step_c) begin
                        if (level_q[i] >= MAX_M1) begin
                            level_d[i] = MAX;
                            state_d[i] = ST_ON;
                        end else begin
                            level_d[i] = level_q[i] + ONE;
                        end
                    end
                end
                ST_ON: begin
                    if (!req_c[i]) state_d[i] = ST_FALL;
                end
                ST_FALL: begin
                    if (req_c[i]) begin
                        dir_flip_c[i] = 1'b1;
                        state_d[i]    = ST_RISE;
                    end else if (step_c) begin
                        if (level_q[i] <= ONE) begin
                            level_d[i] = '0;
                            state_d[i] = ST_OFF;
                        end else begin
                            level_d[i] = level_q[i] - ONE;
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    level_d[i] = '0;
                end
            endcase
        end
    end

    // Pin drive: PWM compare, or the raw synchronised request when bypassed
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            on_c[i]     = (level_q[i] == MAX) || (pwm_cnt_q < level_q[i]);
            moving_c[i] = (state_q[i] == ST_RISE) || (state_q[i] == ST_FALL);
        end
        led_n_d = i_bypass ? ~req_c : ~on_c;
        busy_d  = |moving_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_OFF;
                level_q[i] <= '0;
            end
            led_n_q    <= 2'b11;
            busy_q     <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_cnt_q <= fade_cnt_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                level_q[i] <= level_d[i];
            end
            led_n_q    <= led_n_d;
            busy_q     <= busy_d;
        end
    end

    assign o_led_n = led_n_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver: a time-indexed reference model predicts
// every cycle's pin drive and busy flag; a monitor pops and compares each cycle.
module tb_led_fade_driver;

    localparam int unsigned P    = 2;
    localparam int unsigned B    = 3;
    localparam int unsigned FD   = 1;
    localparam int          MAXV = (1 << B) - 1;
    localparam int          NLVL = 1 << B;
    localparam int          SP   = P * NLVL * FD;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] i_led_n;
    logic       i_bypass;
    logic [1:0] o_led_n;
    logic       o_busy;

    always #5 clk = ~clk;

    led_fade_driver #(
        .PRESCALE (P),
        .PWM_BITS (B),
        .FADE_DIV (FD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_led_n  (i_led_n),
        .i_bypass (i_bypass),
        .o_led_n  (o_led_n),
        .o_busy   (o_busy)
    );

    typedef struct packed {
        logic [1:0] led_n;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_coinc = 0;

    // Model state: mk = clocks since reset; s1/s2 = input history two cycles deep
    int         mk = 0;
    logic [1:0] s1 = 2'b11;
    logic [1:0] s2 = 2'b11;
    int         lvl [2];
    logic       dir [2];
    logic       parked [2];

    exp_t       m_e;
    logic [1:0] m_req;
    logic [1:0] m_on;
    int         m_pwm;
    logic       m_step;

    // Reference model: brightness moves one level per step toward the request,
    // pausing for a step whenever the request direction has just changed
    always @(posedge clk) begin
        if (reset) begin
            m_e.led_n = 2'b11;
            m_e.busy  = 1'b0;
            exp_q.push_back(m_e);
            mk = 0;
            s1 = 2'b11;
            s2 = 2'b11;
            for (int i = 0; i < 2; i++) begin
                lvl[i]    = 0;
                dir[i]    = 1'b0;
                parked[i] = 1'b1;
            end
        end else begin
            m_req  = ~s2;
            m_pwm  = (mk / P) % NLVL;
            m_step = ((mk % SP) == SP - 1);
            m_e.busy = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_on[i] = (lvl[i] == MAXV) || (m_pwm < lvl[i]);
                if (!parked[i]) m_e.busy = 1'b1;
            end
            m_e.led_n = i_bypass ? ~m_req : ~m_on;
            exp_q.push_back(m_e);
            for (int i = 0; i < 2; i++) begin
                if (m_req[i] != dir[i]) begin
                    dir[i]    = m_req[i];
                    parked[i] = 1'b0;
                end else if (m_step && !parked[i]) begin
                    if (dir[i]) begin
                        lvl[i]    = (lvl[i] >= MAXV) ? MAXV : lvl[i] + 1;
                        parked[i] = (lvl[i] == MAXV);
                    end else begin
                        lvl[i]    = (lvl[i] <= 0) ? 0 : lvl[i] - 1;
                        parked[i] = (lvl[i] == 0);
                    end
                end
            end
            s2 = s1;
            s1 = i_led_n;
            mk = mk + 1;
        end
    end

    exp_t mon_e;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            checks = checks + 1;
            if (o_led_n !== mon_e.led_n || o_busy !== mon_e.busy) begin
                errors = errors + 1;
                if (errors <= 20)
                    $display("FAIL pins @%0t cyc=%0d: o_led_n=%b o_busy=%b, expected o_led_n=%b o_busy=%b",
                             $time, mk, o_led_n, o_busy, mon_e.led_n, mon_e.busy);
            end
        end
    end

    // A direction change coinciding with a step must leave the level untouched
    always @(posedge clk) begin
        if (!reset && dut.step_c && (|dut.dir_flip_c)) n_coinc = n_coinc + 1;
    end

    a_coinc0: assert property (@(posedge clk) disable iff (reset)
        (dut.step_c && dut.dir_flip_c[0]) |=> $stable(dut.level_q[0]))
        else begin
            errors = errors + 1;
            $display("FAIL coinc0: level changed=1 on direction flip, expected 0");
        end

    a_coinc1: assert property (@(posedge clk) disable iff (reset)
        (dut.step_c && dut.dir_flip_c[1]) |=> $stable(dut.level_q[1]))
        else begin
            errors = errors + 1;
            $display("FAIL coinc1: level changed=1 on direction flip, expected 0");
        end

    task automatic step_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance until the model clock sits at the given phase of the step period
    task automatic align(input int phase);
        int guard = 0;
        while ((mk % SP) != phase && guard < 4 * SP) begin
            step_n(1);
            guard++;
        end
    endtask

    initial begin
        reset    = 1'b1;
        i_led_n  = 2'b00;
        i_bypass = 1'b0;
        step_n(3);
        reset = 1'b0;
        step_n(40);

        // Single-channel full rise, then full fall
        reset   = 1'b1;
        i_led_n = 2'b10;
        step_n(2);
        reset = 1'b0;
        step_n(130);
        i_led_n = 2'b11;
        step_n(130);

        // Reverse mid-rise, then re-request one period later
        i_led_n = 2'b10;
        step_n(3 + 3 * SP + 8);
        i_led_n = 2'b11;
        step_n(SP);
        i_led_n = 2'b10;
        step_n(100);

        // Request edges landing exactly on a step cycle (req visible two clocks later)
        i_led_n = 2'b11;
        step_n(SP + 3);
        repeat (6) begin
            align(SP - 3);
            i_led_n = i_led_n ^ 2'b11;
            step_n(2 * SP);
        end

        // Bypass: pins follow the request directly, then resume PWM at current level
        i_bypass = 1'b1;
        repeat (12) begin
            i_led_n[0] = ~i_led_n[0];
            step_n($urandom_range(1, 6));
        end
        i_led_n = 2'b10;
        step_n(130);
        i_bypass = 1'b0;
        step_n(24);

        // Random requests with occasional bypass
        repeat (40) begin
            i_led_n  = 2'($urandom_range(0, 3));
            i_bypass = ($urandom_range(0, 7) == 0);
            step_n($urandom_range(1, 40));
        end
        i_bypass = 1'b0;

        // Reset in the middle of a fade aborts it
        i_led_n = 2'b00;
        step_n(50);
        reset = 1'b1;
        step_n(2);
        reset = 1'b0;
        step_n(20);

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (n_coinc == 0) begin
            errors = errors + 1;
            $display("FAIL coinc_hit: direction flips on step=%0d, expected >0", n_coinc);
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: pending expectations=%0d, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
